studio2_mem_arbiter: RTL and testbench

Single-port memory arbiter and sequencer for the Studio II 4 KB system memory. It shares one synchronous RAM port between three requesters: the ROM/cartridge loader, the CDP1802 CPU bus and the Pixie video DMA fetch. It applies the console memory map, meaning mirroring, write protection and open-bus reads, and it keeps the CPU from being starved by video DMA. It sits between the CPU/video/loader front ends and the memory macro.

---
 rtl/studio2_mem_arbiter_pkg.sv | 35 +++
 rtl/studio2_mem_arbiter_addr_decode.sv | 39 +++
 rtl/studio2_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_studio2_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/studio2_mem_arbiter_pkg.sv
// Shared types, memory-map constants and address helpers for the Studio II
// memory arbiter.
package studio2_mem_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2,
    OWN_LDR  = 2'd3
  } owner_e;

  localparam logic [11:0] CART_BASE  = 12'h400;
  localparam logic [11:0] RAM_BASE   = 12'h800;
  localparam logic [11:0] VRAM_BASE  = 12'h900;
  localparam logic [11:0] RAM_MIRROR = 12'hC00;
  localparam logic [7:0]  OPEN_BUS   = 8'hFF;

  // Cartridge images sit above the 1 KB system ROM; the sum wraps at 4 KB.
  function automatic logic [11:0] ldr_phys(input logic [7:0] index, input logic [11:0] offset);
    logic [11:0] base;
    if (index != 8'h00) begin
      base = CART_BASE;
    end else begin
      base = 12'h000;
    end
    return offset + base;
  endfunction

endpackage

// File: rtl/studio2_mem_arbiter_addr_decode.sv
// CPU address decoder: applies the console memory map (mirroring, write
// protection, open bus) to a 12-bit CPU address.
module studio2_addr_decode
  import studio2_mem_pkg::*;
#(
  parameter bit MCART_EN = 1'b0
) (
  input  logic [11:0] addr_i,
  output logic [11:0] phys_addr_o,
  output logic        writable_o,
  output logic        open_bus_o
);

  // Region select on the 512-byte granule number
  always_comb begin
    phys_addr_o = addr_i;
    writable_o  = 1'b0;
    open_bus_o  = 1'b0;
    case (addr_i[11:9])
      3'b000, 3'b001, 3'b010, 3'b011: begin
        writable_o = 1'b0;
      end
      3'b100: begin
        writable_o = 1'b1;
      end
      3'b110: begin
        phys_addr_o = addr_i - (RAM_MIRROR - RAM_BASE);
        writable_o  = 1'b1;
      end
      3'b101, 3'b111: begin
        open_bus_o = ~MCART_EN;
      end
      default: begin
        open_bus_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/studio2_mem_arbiter.sv
// Single-port RAM arbiter for loader, CPU and video DMA with a starvation
// guard for the CPU and a two-cycle registered read return path.
module studio2_mem_arbiter
  import studio2_mem_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 4,
  parameter bit MCART_EN     = 1'b0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ldr_active,
  input  logic        ldr_req,
  input  logic [7:0]  ldr_index,
  input  logic [11:0] ldr_addr,
  input  logic [7:0]  ldr_data,
  output logic        ldr_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic        wp_err,
  input  logic        vid_req,
  input  logic [7:0]  vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_rdata,
  output logic        vid_rvalid,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int WW = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(CPU_MAX_WAIT);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [11:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  owner_e        own_q, own_d;
  logic          ob_q, ob_d;
  logic          wp_err_q, wp_err_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d, vid_rdata_q, vid_rdata_d;
  logic          cpu_rvalid_q, cpu_rvalid_d, vid_rvalid_q, vid_rvalid_d;
  logic [11:0]   dec_addr_s;
  logic          dec_wr_s, dec_ob_s;
  logic          unused_s;

  assign unused_s = ^cpu_addr[15:12];

  studio2_addr_decode #(.MCART_EN(MCART_EN)) u_decode (
    .addr_i      (cpu_addr[11:0]),
    .phys_addr_o (dec_addr_s),
    .writable_o  (dec_wr_s),
    .open_bus_o  (dec_ob_s)
  );

  // Grant selection, RAM port drive and mode sequencing; the first cycle of
  // ldr_active already blocks NORMAL grants so the loader sees a quiet port.
  always_comb begin
    state_d   = state_q;
    ldr_ack   = 1'b0;
    cpu_ack   = 1'b0;
    vid_ack   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    own_d     = OWN_NONE;
    ob_d      = 1'b0;
    wp_err_d  = 1'b0;
    case (state_q)
      NORMAL: begin
        if (ldr_active) begin
          state_d = LOAD;
        end else begin
          state_d = NORMAL;
        end
        if (!reset_n || ldr_active) begin
          own_d = OWN_NONE;
        end else if (cpu_req && (!vid_req || wait_cnt_q == WAIT_MAX)) begin
          cpu_ack   = 1'b1;
          mem_addr  = dec_addr_s;
          mem_wdata = cpu_we ? cpu_wdata : wdata_q;
          mem_we    = cpu_we & dec_wr_s;
          own_d     = cpu_we ? OWN_NONE : OWN_CPU;
          ob_d      = dec_ob_s & ~cpu_we;
          wp_err_d  = cpu_we & ~dec_wr_s;
        end else if (vid_req) begin
          vid_ack  = 1'b1;
          mem_addr = VRAM_BASE + {4'h0, vid_addr};
          own_d    = OWN_VID;
        end else begin
          own_d = OWN_NONE;
        end
      end
      LOAD: begin
        if (!ldr_active) begin
          state_d = DRAIN;
        end else if (ldr_req && reset_n) begin
          ldr_ack   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ldr_phys(ldr_index, ldr_addr);
          mem_wdata = ldr_data;
          own_d     = OWN_LDR;
        end else begin
          state_d = LOAD;
        end
      end
      DRAIN: begin
        state_d = NORMAL;
      end
      default: begin
        state_d = NORMAL;
      end
    endcase
  end

  // CPU starvation counter and held RAM address/data
  always_comb begin
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    if (cpu_ack) begin
      wait_cnt_d = '0;
    end else if (cpu_req && wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Return stage: steer RAM data to the owner tagged at grant
  always_comb begin
    cpu_rvalid_d = (own_q == OWN_CPU);
    vid_rvalid_d = (own_q == OWN_VID);
    cpu_rdata_d  = cpu_rdata_q;
    vid_rdata_d  = vid_rdata_q;
    if (own_q == OWN_CPU) begin
      cpu_rdata_d = ob_q ? OPEN_BUS : mem_rdata;
    end else if (own_q == OWN_VID) begin
      vid_rdata_d = mem_rdata;
    end else begin
      cpu_rdata_d = cpu_rdata_q;
    end
  end

  // State registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= NORMAL;
      wait_cnt_q   <= '0;
      addr_q       <= 12'h000;
      wdata_q      <= 8'h00;
      own_q        <= OWN_NONE;
      ob_q         <= 1'b0;
      wp_err_q     <= 1'b0;
      cpu_rdata_q  <= 8'h00;
      vid_rdata_q  <= 8'h00;
      cpu_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      own_q        <= own_d;
      ob_q         <= ob_d;
      wp_err_q     <= wp_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vid_rdata_q  <= vid_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vid_rvalid_q <= vid_rvalid_d;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign vid_rdata  = vid_rdata_q;
  assign vid_rvalid = vid_rvalid_q;
  assign wp_err     = wp_err_q;

endmodule

// File: tb/tb_studio2_mem_arbiter.sv
// Self-checking bench: RAM fixture, per-cycle reference model of the memory map
// and arbitration rules, and directed scenarios with literal expectations.
module tb_studio2_mem_arbiter;

  localparam int MAXW = 4;
  localparam bit MCART = 1'b0;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ldr_active, ldr_req;
  logic [7:0]  ldr_index, ldr_data;
  logic [11:0] ldr_addr;
  logic        ldr_ack;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_rvalid, wp_err;
  logic        vid_req;
  logic [7:0]  vid_addr, vid_rdata;
  logic        vid_ack, vid_rvalid;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  studio2_mem_arbiter #(.CPU_MAX_WAIT(MAXW), .MCART_EN(MCART)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ldr_active(ldr_active), .ldr_req(ldr_req), .ldr_index(ldr_index),
    .ldr_addr(ldr_addr), .ldr_data(ldr_data), .ldr_ack(ldr_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .wp_err(wp_err),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] pat(input logic [11:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Synchronous RAM fixture; unwritten locations read back a fixed pattern.
  logic [7:0] ram [4096];
  bit         ram_wr [4096];
  always @(posedge clk_sys) begin
    if (mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : pat(mem_addr);
  end

  function automatic logic [7:0] ram_peek(input logic [11:0] a);
    return ram_wr[a] ? ram[a] : pat(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    bit         is_cpu;
    logic [7:0] data;
  } ret_t;

  function automatic void mdec(input logic [15:0] ca, output logic [11:0] pa,
                               output bit wr, output bit ob);
    int a;
    a  = int'(ca[11:0]);
    pa = ca[11:0];
    wr = 1'b0;
    ob = 1'b0;
    if (a >= 'h800 && a < 'hA00) wr = 1'b1;
    else if (a >= 'hC00 && a < 'hE00) begin
      wr = 1'b1;
      pa = 12'(a - 'h400);
    end
    else if (a >= 'hA00) ob = (MCART == 1'b0);
  endfunction

  initial begin : model
    logic [7:0]  shadow [4096];
    ret_t        pend [$];
    int          cyc, mode, wcnt, wp_due;
    logic [11:0] eaddr, pa;
    logic [7:0]  ecpu_rd, evid_rd, ewd;
    bit          eca, eva, ela, ewe, ecv, evv, wr, ob;
    for (int i = 0; i < 4096; i++) shadow[i] = pat(12'(i));
    cyc = 0; mode = 0; wcnt = 0; wp_due = -1;
    eaddr = 12'h000; ecpu_rd = 8'h00; evid_rd = 8'h00;
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (!reset_n) begin
        mode = 0; wcnt = 0; wp_due = -1; eaddr = 12'h000;
        ecpu_rd = 8'h00; evid_rd = 8'h00; pend.delete();
        chk("rst_acks", {ldr_ack, cpu_ack, vid_ack}, 0);
        chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_rvalid", {cpu_rvalid, vid_rvalid, wp_err}, 0);
        chk("rst_rdata", {cpu_rdata, vid_rdata}, 0);
      end else begin
        eca = 0; eva = 0; ela = 0; ewe = 0; ewd = 8'h00;
        mdec(cpu_addr, pa, wr, ob);
        if (mode == 0 && !ldr_active) begin
          if (cpu_req && (!vid_req || wcnt == MAXW)) eca = 1;
          else if (vid_req) eva = 1;
        end else if (mode == 1 && ldr_active && ldr_req) ela = 1;
        if (eca) begin
          eaddr = pa;
          ewe = cpu_we && wr;
          ewd = cpu_wdata;
        end
        if (eva) eaddr = 12'(32'h900 + vid_addr);
        if (ela) begin
          eaddr = 12'((int'(ldr_addr) + ((ldr_index != 0) ? 'h400 : 0)) % 4096);
          ewe = 1;
          ewd = ldr_data;
        end
        ecv = 0; evv = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          if (pend[0].is_cpu) begin ecv = 1; ecpu_rd = pend[0].data; end
          else begin evv = 1; evid_rd = pend[0].data; end
          void'(pend.pop_front());
        end
        chk("ldr_ack", ldr_ack, ela);
        chk("cpu_ack", cpu_ack, eca);
        chk("vid_ack", vid_ack, eva);
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, eaddr);
        if (ewe) chk("mem_wdata", mem_wdata, ewd);
        chk("cpu_rvalid", cpu_rvalid, ecv);
        chk("vid_rvalid", vid_rvalid, evv);
        chk("cpu_rdata", cpu_rdata, ecpu_rd);
        chk("vid_rdata", vid_rdata, evid_rd);
        chk("wp_err", wp_err, (cyc == wp_due));
        // advance the model to the next cycle
        if (mode == 0 && ldr_active) mode = 1;
        else if (mode == 1 && !ldr_active) mode = 2;
        else if (mode == 2) mode = 0;
        if (eca) wcnt = 0;
        else if (cpu_req && wcnt < MAXW) wcnt++;
        if (eca && !cpu_we) pend.push_back('{cyc + 2, 1'b1, ob ? 8'hFF : shadow[pa]});
        if (eca && cpu_we && !wr) wp_due = cyc + 1;
        if (eva) pend.push_back('{cyc + 2, 1'b0, shadow[eaddr]});
        if (ewe) shadow[eaddr] = ewd;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] d,
                        output logic [7:0] rd);
    int n;
    @(posedge clk_sys); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    n = 0;
    do begin @(negedge clk_sys); n++; end while (!cpu_ack && n < 20);
    chk("cpu_ack_seen", cpu_ack, 1);
    @(posedge clk_sys); #1;
    cpu_req = 1'b0;
    rd = 8'h00;
    if (!we) begin
      @(negedge clk_sys);
      @(negedge clk_sys);
      chk("cpu_rvalid_n2", cpu_rvalid, 1);
      rd = cpu_rdata;
    end
  endtask

  task automatic vid_op(input logic [7:0] a, output logic [7:0] rd);
    int n;
    @(posedge clk_sys); #1;
    vid_req = 1'b1; vid_addr = a;
    n = 0;
    do begin @(negedge clk_sys); n++; end while (!vid_ack && n < 20);
    chk("vid_ack_seen", vid_ack, 1);
    @(posedge clk_sys); #1;
    vid_req = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("vid_rvalid_n2", vid_rvalid, 1);
    rd = vid_rdata;
  endtask

  task automatic ldr_write(input logic [7:0] idx, input logic [11:0] a, input logic [7:0] d);
    int n;
    @(posedge clk_sys); #1;
    ldr_req = 1'b1; ldr_index = idx; ldr_addr = a; ldr_data = d;
    n = 0;
    do begin @(negedge clk_sys); n++; end while (!ldr_ack && n < 20);
    chk("ldr_ack_seen", ldr_ack, 1);
    @(posedge clk_sys); #1;
    ldr_req = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] rd;
    int n;
    reset_n = 1'b0;
    ldr_active = 1'b0; ldr_req = 1'b0; ldr_index = 8'h00; ldr_addr = 12'h000; ldr_data = 8'h00;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    vid_req = 1'b0; vid_addr = 8'h00;
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;

    // loader requests outside a session are ignored
    ldr_req = 1'b1; ldr_addr = 12'h055; ldr_data = 8'hEE;
    repeat (2) @(posedge clk_sys);
    #1 ldr_req = 1'b0;
    repeat (2) @(posedge clk_sys);
    chk("ldr_ignored_ram", ram_peek(12'h055), 8'h0F);

    // loader session: cart, system ROM, and wrap-around at 4 KB
    #1 ldr_active = 1'b1;
    ldr_write(8'h01, 12'h010, 8'hA5);
    ldr_write(8'h00, 12'h010, 8'hC3);
    ldr_write(8'h07, 12'hFF0, 8'h11);
    @(posedge clk_sys); #1 ldr_active = 1'b0;
    repeat (3) @(posedge clk_sys);
    chk("ldr_cart_ram", ram_peek(12'h410), 8'hA5);
    chk("ldr_rom_ram", ram_peek(12'h010), 8'hC3);
    chk("ldr_wrap_ram", ram_peek(12'h3F0), 8'h11);

    cpu_op(1'b0, 16'h0410, 8'h00, rd);  chk("rd_cart", rd, 8'hA5);
    cpu_op(1'b0, 16'hF010, 8'h00, rd);  chk("rd_rom_hi_ignored", rd, 8'hC3);
    cpu_op(1'b1, 16'h0C20, 8'h3C, rd);
    cpu_op(1'b0, 16'h0820, 8'h00, rd);  chk("rd_mirror_write", rd, 8'h3C);
    vid_op(8'h20, rd);                  chk("vid_rd_920", rd, 8'h7A);
    cpu_op(1'b1, 16'h0100, 8'h77, rd);
    @(posedge clk_sys);
    chk("rom_protected", ram_peek(12'h100), 8'h5A);
    cpu_op(1'b0, 16'h0A00, 8'h00, rd);  chk("open_bus_a00", rd, 8'hFF);
    cpu_op(1'b0, 16'h0E05, 8'h00, rd);  chk("open_bus_e05", rd, 8'hFF);
    cpu_op(1'b1, 16'h0B00, 8'h99, rd);
    cpu_op(1'b0, 16'h0100, 8'h00, rd);  chk("rom_unchanged_rd", rd, 8'h5A);

    // starvation guard: video continuously requesting
    @(posedge clk_sys); #1;
    vid_req = 1'b1; vid_addr = 8'h20;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0820;
    n = 0;
    do begin @(negedge clk_sys); n++; end while (!cpu_ack && n < 20);
    chk("starve_cycles", n, 5);
    @(posedge clk_sys); #1 cpu_req = 1'b0;
    @(negedge clk_sys);
    chk("vid_regains", vid_ack, 1);

    // loader session opened during CPU/video traffic
    @(posedge clk_sys); #1 cpu_req = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1 ldr_active = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 ldr_active = 1'b0;
    n = 0;
    do begin @(negedge clk_sys); n++; end while (!(cpu_ack || vid_ack) && n < 20);
    chk("drain_gap", n, 3);
    @(posedge clk_sys); #1 cpu_req = 1'b0; vid_req = 1'b0;
    repeat (3) @(posedge clk_sys);

    // reset one cycle after a read grant kills the return
    #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0820;
    @(negedge clk_sys);
    chk("pre_rst_ack", cpu_ack, 1);
    @(posedge clk_sys); #1 cpu_req = 1'b0; reset_n = 1'b0;
    @(negedge clk_sys);
    chk("rst_cpu_rdata", cpu_rdata, 8'h00);
    @(posedge clk_sys); #1 reset_n = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk_sys);
      if (cpu_rvalid) n++;
    end
    chk("no_rvalid_after_rst", n, 0);

    repeat (2) @(posedge clk_sys);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
